// File: rtl/deser_queue_pkg.sv
// Shared types and default sizing for the serial-to-parallel word queue.
package deser_queue_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 8;

endpackage

// File: rtl/deser_queue_bit_collector.sv
// Shifts serial bits into a word; word/word_done present the completed word
// combinationally on the cycle its last bit is sampled, so it is stored on that edge.
module bit_collector
  import deser_queue_pkg::*;
#(
  parameter int         DATA_W    = DEFAULT_DATA_W,
  parameter bit_order_e BIT_ORDER = MSB_FIRST
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_in,
  input  logic              write_in,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [CNT_W-1:0]  bit_cnt_next;
  logic              last_bit;

  generate
    if (BIT_ORDER == MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_reg[DATA_W-2:0], data_in};
    end else begin : g_lsb_first
      assign shifted = {data_in, shift_reg[DATA_W-1:1]};
    end
  endgenerate

  assign last_bit  = (bit_cnt_reg == CNT_W'(DATA_W - 1));
  assign word      = shifted;
  assign word_done = write_in && last_bit;

  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    if (write_in) begin
      shift_next   = shifted;
      bit_cnt_next = last_bit ? '0 : bit_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

endmodule

// File: rtl/deser_queue.sv
// Serial deserializer feeding a DEPTH-entry word queue with registered pop output
// and a sticky overflow flag for words that arrive while the queue is full.
module deser_queue
  import deser_queue_pkg::*;
#(
  parameter int         DATA_W    = DEFAULT_DATA_W,
  parameter int         DEPTH     = DEFAULT_DEPTH,
  parameter bit_order_e BIT_ORDER = MSB_FIRST
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  input  logic                       clear_ovf_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_out_valid,
  output logic [$clog2(DEPTH+1)-1:0] len,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] word;
  logic              word_done;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  len_next;
  logic              full_reg;
  logic              empty_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_out_valid_reg;

  logic pop;
  logic push;
  logic drop;

  bit_collector #(
    .DATA_W    (DATA_W),
    .BIT_ORDER (BIT_ORDER)
  ) u_bit_collector (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .write_in  (write_in),
    .word      (word),
    .word_done (word_done)
  );

  // A pop frees the head slot on the same edge, so a full queue can still accept.
  assign pop  = dequeue_in && !empty_reg;
  assign push = word_done && (!full_reg || pop);
  assign drop = word_done && full_reg && !pop;

  always_comb begin
    len_next = len_reg;
    case ({push, pop})
      2'b10:   len_next = len_reg + LEN_W'(1);
      2'b01:   len_next = len_reg - LEN_W'(1);
      default: len_next = len_reg;
    endcase
  end

  // Storage is never reset; len gates every read so stale entries stay hidden.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      len_reg            <= '0;
      full_reg           <= 1'b0;
      empty_reg          <= 1'b1;
      overflow_reg       <= 1'b0;
      data_out_reg       <= '0;
      data_out_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        data_out_reg <= mem[rd_ptr_reg];
      end
      data_out_valid_reg <= pop;
      len_reg            <= len_next;
      full_reg           <= (len_next == LEN_W'(DEPTH));
      empty_reg          <= (len_next == '0);
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_ovf_in) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign data_out       = data_out_reg;
  assign data_out_valid = data_out_valid_reg;
  assign len            = len_reg;
  assign full           = full_reg;
  assign empty          = empty_reg;
  assign overflow       = overflow_reg;

endmodule

// File: doc/deser_queue.md
DESER_QUEUE -- requirements
Module: deser_queue

Interface
REQ-001 Parameter DATA_W, default 8, meaning word width in bits; legal range 2..32.
REQ-002 Parameter DEPTH, default 8, meaning queue entries; power of two, legal range 2..64.
REQ-003 Parameter BIT_ORDER, default MSB_FIRST, meaning serial bit order, of package type bit_order_e.
REQ-004 clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  meaning asynchronous active-low reset.
REQ-006 data_in  input  1  meaning serial data bit.
REQ-007 write_in  input  1  meaning data_in is valid this cycle.
REQ-008 dequeue_in  input  1  meaning pop the head entry.
REQ-009 clear_ovf_in  input  1  meaning clear the sticky overflow flag.
REQ-010 data_out  output  DATA_W  meaning the last popped word, registered.
REQ-011 data_out_valid  output  1  meaning one-cycle pulse: data_out was updated by a pop.
REQ-012 len  output  $clog2(DEPTH+1)  meaning entries held, 0..DEPTH.
REQ-013 full  output  1  meaning len == DEPTH.
REQ-014 empty  output  1  meaning len == 0.
REQ-015 overflow  output  1  meaning sticky flag: a completed word was dropped.

Function
REQ-016 Each cycle with write_in=1 shall sample data_in into the shift register and increment bit_cnt (0..DATA_W-1); write_in=0 shall hold both.
REQ-017 MSB_FIRST: first sampled bit lands in word bit DATA_W-1; LSB_FIRST: first sampled bit lands in bit 0.
REQ-018 Word completion is the edge sampling bit DATA_W-1; bit_cnt wraps to 0 on that same edge, so back-to-back words need no idle cycle.
REQ-019 A completed word shall be written into the queue on its completion edge (zero extra latency); len reflects it the following cycle.
REQ-020 Completion while full with no pop that cycle: word discarded, queue unchanged, overflow set on that edge.
REQ-021 Completion and dequeue_in=1 in the same cycle while full: both accepted, len unchanged, no overflow.
REQ-022 dequeue_in=1 while not empty: data_out <= head entry, read pointer +1 mod DEPTH, data_out_valid=1 next cycle, len -1 (net 0 when an enqueue also occurs).
REQ-023 dequeue_in=1 while empty: ignored; data_out holds, data_out_valid=0, len stays 0; completion in that same cycle still enqueues.
REQ-024 Read and write pointers shall wrap modulo DEPTH; len is an explicit counter, not derived from pointer difference.
REQ-025 clear_ovf_in=1 clears overflow; clear and a new drop in the same cycle leave overflow=1 (set wins).
REQ-026 full, empty, and len shall be registered and mutually consistent every cycle.

Reset
REQ-027 reset_n=0 shall immediately clear bit_cnt, the shift register, both pointers, len, data_out, data_out_valid, and overflow; empty=1, full=0.
REQ-028 A partial word in progress at reset shall be discarded, not enqueued.
REQ-029 Queue storage contents need not be cleared; no stale entry is readable because len=0.
REQ-030 Deassertion needs no internal synchronizer; reset_n is synchronised upstream.

Structure
REQ-031 Package deser_queue_pkg shall hold enum bit_order_e {LSB_FIRST, MSB_FIRST} and the default DATA_W/DEPTH constants.
REQ-032 One sub-module, bit_collector, shall contain the shift register and bit_cnt and output word plus a one-cycle word_done strobe; queue logic lives in deser_queue.

Verification
REQ-033 DATA_W=8, MSB_FIRST: serial bits 1,0,1,0,0,1,0,1 with write_in=1, then pop -> data_out=0xA5, data_out_valid pulses once, len 1->0.
REQ-034 LSB_FIRST, same bit stream -> data_out=0xA5 bit-reversed = 0xA5; use 0x01 stream (1,0,0,0,0,0,0,0) -> data_out=0x01.
REQ-035 DEPTH=4: enqueue 0x11,0x22,0x33,0x44, then 0x55 -> full=1, overflow=1, pops return 0x11..0x44 in order, 0x55 never appears.
REQ-036 Full queue, completion of 0x66 in the same cycle as a pop -> popped head returned, 0x66 stored, len stays 4, overflow=0.
REQ-037 reset_n=0 after 5 of 8 bits, release, then send 8 new bits encoding 0x3C -> only 0x3C is queued, len=1.
REQ-038 Pop while empty -> data_out unchanged, data_out_valid=0, len=0; wrap test: 10 enqueue/pop pairs with DEPTH=4 return the correct sequence.
